booth_digit_accumulator: RTL and testbench

- Consumer end of the radix-4 Booth encoder interface.
- Accepts a stream of encoded Booth digits {single, double, negate}, least-significant digit first, over a valid/ready handshake.
- Decodes each digit against a latched signed multiplicand and accumulates the shifted partial products.
- Delivers the full signed 2*WIDTH product after WIDTH/2 digits; it is the sequential multiplier back end that sits behind the encoder array.

---
 rtl/booth_digit_accumulator.sv | 110 +++++++++++
 tb/tb_booth_digit_accumulator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_digit_accumulator.sv
// Radix-4 Booth back end: folds NDIG shifted partial products of a latched multiplicand into a 2*WIDTH product.
// One digit per cycle, done pulses the cycle after the last accept; dig_valid stalls simply hold state.
module booth_digit_accumulator #(
  parameter int WIDTH = 8,
  localparam int NDIG = WIDTH / 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   mcand,
  input  logic                      dig_valid,
  output logic                      dig_ready,
  input  logic                      single,
  input  logic                      double,
  input  logic                      negate,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] product,
  output logic                      err
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int AW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
  state_t state, state_nxt;

  logic signed [WIDTH-1:0] mcand_q;
  logic signed [WIDTH+1:0] m_ext, mag, pp;
  logic signed [AW-1:0]    acc, acc_nxt, pp_ext, pp_sh;
  logic [KW-1:0]           k;
  logic                    accept, last, illegal;

  assign illegal = single & double;
  assign accept  = dig_valid & dig_ready;
  assign last    = (k == KW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dig_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        dig_ready = 1'b1;
        busy      = 1'b1;
        if (dig_valid && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Two guard bits so that 2M and its negation of the most negative M stay representable.
  always_comb begin
    m_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
    mag   = '0;
    if (!illegal) begin
      if (single)      mag = m_ext;
      else if (double) mag = m_ext <<< 1;
    end
    pp      = negate ? -mag : mag;
    pp_ext  = {{(AW - WIDTH - 2){pp[WIDTH+1]}}, pp};
    pp_sh   = pp_ext <<< {k, 1'b0};
    acc_nxt = acc + pp_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc     <= '0;
      k       <= '0;
      product <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand_q <= mcand;
            acc     <= '0;
            k       <= '0;
            err     <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc <= acc_nxt;
            k   <= k + KW'(1);
            if (illegal) err <= 1'b1;
            if (last) product <= acc_nxt[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_digit_accumulator.sv
// Bench for booth_digit_accumulator: directed cases plus random digit streams checked against an arithmetic model.
module tb_booth_digit_accumulator;
  localparam int W  = 8;
  localparam int ND = W / 2;

  typedef logic [2:0] dig_arr_t [ND];  // each entry {single, double, negate}

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic           dig_valid = 1'b0;
  logic           single = 1'b0, double = 1'b0, negate = 1'b0;
  logic           dig_ready, busy, done, err;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  booth_digit_accumulator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand),
    .dig_valid(dig_valid), .dig_ready(dig_ready),
    .single(single), .double(double), .negate(negate),
    .busy(busy), .done(done), .product(product), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Multiplier value is the sum of signed digit values times 4^k; product is its low 2W bits.
  function automatic logic [2*W-1:0] model_product(input logic [W-1:0] m, input dig_arr_t dg);
    longint mult = 0;
    longint full;
    logic [63:0] bits;
    for (int i = 0; i < ND; i++) begin
      longint v;
      if (dg[i][2] && dg[i][1]) v = 0;
      else if (dg[i][2])        v = 1;
      else if (dg[i][1])        v = 2;
      else                      v = 0;
      if (dg[i][0]) v = -v;
      mult += v * (longint'(1) << (2 * i));
    end
    full = longint'($signed(m)) * mult;
    bits = full;
    return bits[2*W-1:0];
  endfunction

  function automatic logic model_err(input dig_arr_t dg);
    for (int i = 0; i < ND; i++)
      if (dg[i][2] && dg[i][1]) return 1'b1;
    return 1'b0;
  endfunction

  // Runs one product from an IDLE negedge; returns on the negedge after the DONE cycle.
  task automatic run_product(input logic [W-1:0] m, input dig_arr_t dg, input int stall, input bit poke,
                             output logic [2*W-1:0] p, output logic e, output int done_cyc,
                             output logic busy_after);
    int cyc = 0;
    int idx = 0;
    int left = stall;
    bit acc_now;
    p = '0; e = 1'b0; done_cyc = -1;
    start = 1'b1; mcand = m; dig_valid = 1'b0;
    @(negedge clk); cyc = 1; start = 1'b0;
    while (idx < ND && cyc < 400) begin
      if (left > 0) begin
        dig_valid = 1'b0; start = poke; mcand = W'($urandom);
        {single, double, negate} = 3'($urandom);
        left--;
      end else begin
        dig_valid = 1'b1; start = 1'b0;
        {single, double, negate} = dg[idx];
      end
      acc_now = dig_valid & dig_ready;
      @(negedge clk); cyc++;
      if (acc_now) begin idx++; left = stall; end
    end
    dig_valid = 1'b0; {single, double, negate} = 3'b000; start = poke;
    for (int t = 0; t < 40; t++) begin
      if (done) begin done_cyc = cyc; p = product; e = err; break; end
      @(negedge clk); cyc++; start = 1'b0;
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); busy_after = busy;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (dig_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dig_ready: got %b want 0", dig_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (product !== 16'h0)  begin n_fail++; $display("FAIL reset_product: got %h want 0000", product); end
    n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    dig_arr_t dg = '{3'b101, 3'b100, 3'b000, 3'b000};
    logic [2*W-1:0] p; logic e, ba; int dc;
    run_product(8'd7, dg, 0, 1'b0, p, e, dc, ba);
    n_checks++; if (p !== 16'h0015)  begin n_fail++; $display("FAIL basic_product: got %h want 0015", p); end
    n_checks++; if (e !== 1'b0)      begin n_fail++; $display("FAIL basic_err: got %b want 0", e); end
    n_checks++; if (dc !== ND + 1)   begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, ND + 1); end
    n_checks++; if (ba !== 1'b0)     begin n_fail++; $display("FAIL basic_idle_after: busy %b want 0", ba); end
    repeat (3) @(negedge clk);
    n_checks++; if (product !== 16'h0015 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: product %h done %b want 0015/0", product, done);
    end
  endtask

  task automatic test_corners();
    dig_arr_t dg_min = '{3'b000, 3'b000, 3'b000, 3'b011};
    dig_arr_t dg_m1  = '{3'b101, 3'b001, 3'b001, 3'b001};
    logic [2*W-1:0] p; logic e, ba; int dc;
    run_product(8'h80, dg_min, 0, 1'b0, p, e, dc, ba);
    n_checks++; if (p !== 16'h4000) begin n_fail++; $display("FAIL minmin_product: got %h want 4000", p); end
    run_product(8'd127, dg_m1, 0, 1'b0, p, e, dc, ba);
    n_checks++; if (p !== 16'hFF81) begin n_fail++; $display("FAIL neg_one_product: got %h want ff81", p); end
    n_checks++; if (e !== 1'b0)     begin n_fail++; $display("FAIL neg_one_err: got %b want 0", e); end
  endtask

  task automatic test_stall();
    dig_arr_t dg = '{3'b101, 3'b100, 3'b000, 3'b000};
    logic [2*W-1:0] p; logic e, ba; int dc;
    run_product(8'd7, dg, 3, 1'b1, p, e, dc, ba);
    n_checks++; if (p !== 16'h0015)       begin n_fail++; $display("FAIL stall_product: got %h want 0015", p); end
    n_checks++; if (dc !== 4 * ND + 1)    begin n_fail++; $display("FAIL stall_done_cycle: got %0d want %0d", dc, 4 * ND + 1); end
    n_checks++; if (ba !== 1'b0)          begin n_fail++; $display("FAIL stall_start_in_done: busy %b want 0", ba); end
  endtask

  task automatic test_illegal();
    dig_arr_t dg  = '{3'b000, 3'b000, 3'b110, 3'b000};
    dig_arr_t dg2 = '{3'b101, 3'b100, 3'b000, 3'b000};
    logic [2*W-1:0] p; logic e, ba; int dc;
    run_product(8'd9, dg, 0, 1'b0, p, e, dc, ba);
    n_checks++; if (p !== 16'h0000) begin n_fail++; $display("FAIL illegal_product: got %h want 0000", p); end
    n_checks++; if (e !== 1'b1)     begin n_fail++; $display("FAIL illegal_err: got %b want 1", e); end
    repeat (2) @(negedge clk);
    n_checks++; if (err !== 1'b1)   begin n_fail++; $display("FAIL illegal_err_sticky: got %b want 1", err); end
    start = 1'b1; mcand = 8'd7;
    @(negedge clk); start = 1'b0;
    n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL illegal_err_clear: got %b want 0", err); end
    // Let that product run out with all-zero digits, then a clean one.
    dig_valid = 1'b1; {single, double, negate} = 3'b000;
    repeat (ND) @(negedge clk);
    dig_valid = 1'b0;
    repeat (2) @(negedge clk);
    run_product(8'd7, dg2, 0, 1'b0, p, e, dc, ba);
    n_checks++; if (p !== 16'h0015 || e !== 1'b0) begin
      n_fail++; $display("FAIL illegal_recover: product %h err %b want 0015/0", p, e);
    end
  endtask

  task automatic test_reset_mid();
    dig_arr_t dg;
    logic [2*W-1:0] p; logic e, ba; int dc; int dones = 0;
    start = 1'b1; mcand = 8'd5;
    @(negedge clk); start = 1'b0; dig_valid = 1'b1; {single, double, negate} = 3'b110;
    @(negedge clk); {single, double, negate} = 3'b100;
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: err %b busy %b want 1/1", err, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({dig_ready, busy, done, err} !== 4'b0 || product !== 16'h0) begin
      n_fail++; $display("FAIL midreset_clear: rdy %b busy %b done %b err %b product %h want all 0",
                         dig_ready, busy, done, err, product);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (done || busy) dones++; end
    dig_valid = 1'b0;
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles want 0", dones); end
    for (int i = 0; i < ND; i++) dg[i] = {1'b0, 1'b1, i[0]};
    run_product(8'hFD, dg, 0, 1'b0, p, e, dc, ba);
    n_checks++; if (p !== model_product(8'hFD, dg)) begin
      n_fail++; $display("FAIL midreset_fresh: got %h want %h", p, model_product(8'hFD, dg));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      dig_arr_t dg;
      logic [W-1:0] m = W'($urandom);
      int stall = $urandom_range(0, 2);
      bit poke = 1'($urandom);
      logic [2*W-1:0] p; logic e, ba; int dc;
      for (int i = 0; i < ND; i++) begin
        logic s, d;
        if ($urandom_range(0, 15) == 0) dg[i] = {2'b11, 1'($urandom)};
        else begin
          s = 1'($urandom);
          d = s ? 1'b0 : 1'($urandom);
          dg[i] = {s, d, 1'($urandom)};
        end
      end
      run_product(m, dg, stall, poke, p, e, dc, ba);
      n_checks++; if (p !== model_product(m, dg)) begin
        n_fail++; $display("FAIL random_product[%0d]: got %h want %h", it, p, model_product(m, dg));
      end
      n_checks++; if (e !== model_err(dg)) begin
        n_fail++; $display("FAIL random_err[%0d]: got %b want %b", it, e, model_err(dg));
      end
      n_checks++; if (dc !== 1 + ND * (stall + 1) || ba !== 1'b0) begin
        n_fail++; $display("FAIL random_timing[%0d]: done cycle %0d busy_after %b want %0d/0",
                           it, dc, ba, 1 + ND * (stall + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 5; it++) begin
      dig_arr_t dg;
      logic [W-1:0] m = W'($urandom);
      logic [2*W-1:0] p; logic e, ba; int dc;
      for (int i = 0; i < ND; i++) dg[i] = {1'b1, 1'b0, 1'($urandom)};
      run_product(m, dg, 0, 1'b1, p, e, dc, ba);
      n_checks++; if (p !== model_product(m, dg) || dc !== ND + 1) begin
        n_fail++; $display("FAIL back_to_back[%0d]: product %h cycle %0d want %h/%0d",
                           it, p, dc, model_product(m, dg), ND + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
